// File: rtl/code_lock_pkg.sv
// Shared types and constants for the switch-based code entry sequencer.
package code_lock_pkg;

  localparam int NUM_SW    = 10;
  localparam int NUM_DIGIT = 4;
  localparam int NIB       = 4;

  localparam logic [NIB-1:0]           BLANK_NIB  = 4'hF;
  localparam logic [NUM_DIGIT*NIB-1:0] BLANK_CODE = {NUM_DIGIT{BLANK_NIB}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_SET     = 3'd6
  } state_t;

  // Index of the set bit in a one-hot switch vector (caller guarantees one-hot).
  function automatic logic [NIB-1:0] onehot_idx(input logic [NUM_SW-1:0] v);
    logic [NIB-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_SW; k++) begin
      if (v[k]) idx = NIB'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser plus stability filter: a level change is accepted only
// after DEB_CYC consecutive samples that differ from the current filtered level.
module sw_debounce #(
  parameter logic [19:0] DEB_CYC = 20'd500000,
  parameter int          WIDTH   = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_filt;
  logic [19:0]      r_cnt [WIDTH];

  // NOTE: non-blocking throughout so every flop samples the values from before the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      // NOTE: the counter bank is ordinary flops, not a RAM, so it is cleared with everything else.
      for (int k = 0; k < WIDTH; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < WIDTH; k++) begin
        if (r_sync2[k] == r_filt[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DEB_CYC - 20'd1) begin
          r_filt[k] <= r_sync2[k];
          r_cnt[k]  <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 20'd1;
        end
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/code_entry_ctrl.sv
// Code entry sequencer: debounced switches become digits, four digits are checked against
// the stored password, with unlock window, failure lockout and password change.
module code_entry_ctrl
  import code_lock_pkg::*;
#(
  parameter logic [19:0] DEB_CYC  = 20'd500000,
  parameter logic [31:0] TMO_CYC  = 32'd500000000,
  parameter logic [31:0] OPEN_CYC = 32'd250000000,
  parameter logic [31:0] LOCK_CYC = 32'd1000000000,
  parameter logic [1:0]  MAX_FAIL = 2'd3,
  parameter logic [15:0] DEF_PWD  = 16'h1234
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_SW-1:0]         SW,
  input  logic                      BTN_SET,
  input  logic                      BTN_CLR,
  output logic [NUM_DIGIT*NIB-1:0]  CODE_DISP,
  output logic [2:0]                DIGIT_CNT,
  output logic                      UNLOCK,
  output logic                      ALARM,
  output logic                      SET_MODE,
  output logic [2:0]                STATE
);

  localparam int IN_W = NUM_SW + 2;

  logic [IN_W-1:0]          w_filt;
  logic [IN_W-1:0]          r_filt_d;
  logic [NUM_SW-1:0]        w_sw_rise;
  logic                     w_digit_evt;
  logic [NIB-1:0]           w_digit;
  logic                     w_set_evt;
  logic                     w_clr_evt;

  state_t                   r_state,  w_state_nxt;
  logic [NUM_DIGIT*NIB-1:0] r_code,   w_code_nxt;
  logic [NUM_DIGIT*NIB-1:0] w_code_wr;
  logic [2:0]               r_cnt,    w_cnt_nxt;
  logic [15:0]              r_pwd,    w_pwd_nxt;
  logic [1:0]               r_fail,   w_fail_nxt;
  logic [31:0]              r_timer,  w_timer_nxt;
  logic                     w_tmo;
  logic                     w_last;
  logic                     w_dig_take;
  logic                     r_unlock, r_alarm, r_set_mode;

  sw_debounce #(
    .DEB_CYC (DEB_CYC),
    .WIDTH   (IN_W)
  ) u_deb (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_raw   ({BTN_CLR, BTN_SET, SW}),
    .o_filt  (w_filt)
  );

  // A digit needs exactly one rising switch and every switch low on the previous cycle.
  assign w_sw_rise   = w_filt[NUM_SW-1:0] & ~r_filt_d[NUM_SW-1:0];
  assign w_digit_evt = $onehot(w_sw_rise) && (r_filt_d[NUM_SW-1:0] == '0);
  assign w_digit     = onehot_idx(w_sw_rise);
  assign w_set_evt   = w_filt[NUM_SW]   & ~r_filt_d[NUM_SW];
  assign w_clr_evt   = w_filt[NUM_SW+1] & ~r_filt_d[NUM_SW+1];

  assign w_tmo  = (r_timer == '0);
  assign w_last = (r_cnt == 3'(NUM_DIGIT - 1));

  always_comb begin
    w_code_wr = r_code;
    w_code_wr[NIB*r_cnt[1:0] +: NIB] = w_digit;
  end

  function automatic logic [31:0] f_reload(input state_t s);
    case (s)
      S_ENTRY, S_SET: f_reload = TMO_CYC - 32'd1;
      S_OPEN:         f_reload = OPEN_CYC - 32'd1;
      S_LOCKOUT:      f_reload = LOCK_CYC - 32'd1;
      default:        f_reload = '0;
    endcase
  endfunction

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_pwd_nxt   = r_pwd;
    w_fail_nxt  = r_fail;
    w_dig_take  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_clr_evt && w_digit_evt) begin
          w_dig_take  = 1'b1;
          w_code_nxt  = w_code_wr;
          w_cnt_nxt   = r_cnt + 3'd1;
          w_state_nxt = S_ENTRY;
        end
      end
      S_ENTRY, S_SET: begin
        if (w_clr_evt || w_tmo) begin
          w_code_nxt  = BLANK_CODE;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_digit_evt) begin
          w_dig_take = 1'b1;
          if (!w_last) begin
            w_code_nxt = w_code_wr;
            w_cnt_nxt  = r_cnt + 3'd1;
          end else if (r_state == S_SET) begin
            w_pwd_nxt   = w_code_wr;
            w_code_nxt  = BLANK_CODE;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_code_nxt  = w_code_wr;
            w_cnt_nxt   = r_cnt + 3'd1;
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (r_code == r_pwd) begin
          w_fail_nxt  = '0;
          w_state_nxt = S_OPEN;
        end else begin
          w_fail_nxt  = (r_fail == 2'd3) ? r_fail : r_fail + 2'd1;
          w_state_nxt = S_FAIL;
        end
      end
      S_FAIL: begin
        w_code_nxt  = BLANK_CODE;
        w_cnt_nxt   = '0;
        w_state_nxt = (r_fail == MAX_FAIL) ? S_LOCKOUT : S_IDLE;
      end
      S_OPEN: begin
        if (w_set_evt) begin
          w_code_nxt  = BLANK_CODE;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SET;
        end else if (w_tmo) begin
          w_code_nxt  = BLANK_CODE;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (w_tmo) begin
          w_fail_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_code_nxt  = BLANK_CODE;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // One shared down-counter: reloaded on any state change or accepted digit.
    w_timer_nxt = w_tmo ? r_timer : r_timer - 32'd1;
    if ((w_state_nxt != r_state) || w_dig_take) w_timer_nxt = f_reload(w_state_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_filt_d   <= '0;
      r_state    <= S_IDLE;
      r_code     <= BLANK_CODE;
      r_cnt      <= '0;
      r_pwd      <= DEF_PWD;
      r_fail     <= '0;
      r_timer    <= '0;
      r_unlock   <= 1'b0;
      r_alarm    <= 1'b0;
      r_set_mode <= 1'b0;
    end else begin
      r_filt_d   <= w_filt;
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pwd      <= w_pwd_nxt;
      r_fail     <= w_fail_nxt;
      r_timer    <= w_timer_nxt;
      r_unlock   <= (w_state_nxt == S_OPEN);
      r_alarm    <= (w_state_nxt == S_LOCKOUT);
      r_set_mode <= (w_state_nxt == S_SET);
    end
  end

  assign CODE_DISP = r_code;
  assign DIGIT_CNT = r_cnt;
  assign UNLOCK    = r_unlock;
  assign ALARM     = r_alarm;
  assign SET_MODE  = r_set_mode;
  assign STATE     = r_state;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboard bench: a behavioural model queues every expected output snapshot (and how long
// it should persist); a negedge monitor pops one per observed output change and compares.
module tb_code_entry_ctrl;
  import code_lock_pkg::*;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [31:0] TMO = 32'd100;
  localparam logic [31:0] OPN = 32'd20;
  localparam logic [31:0] LCK = 32'd50;
  localparam logic [15:0] DEF = 16'h1234;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  SW = '0;
  logic        BTN_SET = 1'b0;
  logic        BTN_CLR = 1'b0;
  logic [15:0] CODE_DISP;
  logic [2:0]  DIGIT_CNT;
  logic        UNLOCK, ALARM, SET_MODE;
  logic [2:0]  STATE;

  always #5 CLK = ~CLK;

  code_entry_ctrl #(
    .DEB_CYC (DEB), .TMO_CYC (TMO), .OPEN_CYC (OPN), .LOCK_CYC (LCK),
    .MAX_FAIL (2'd3), .DEF_PWD (DEF)
  ) dut (
    .CLK (CLK), .RESET (RESET), .SW (SW), .BTN_SET (BTN_SET), .BTN_CLR (BTN_CLR),
    .CODE_DISP (CODE_DISP), .DIGIT_CNT (DIGIT_CNT), .UNLOCK (UNLOCK), .ALARM (ALARM),
    .SET_MODE (SET_MODE), .STATE (STATE)
  );

  typedef struct packed {
    logic [15:0] code;
    logic [2:0]  cnt;
    logic [2:0]  st;
    logic        unl;
    logic        alm;
    logic        setm;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dwell;   // expected cycles this snapshot persists, 0 = not checked
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_fail = 0;

  state_t      m_state;
  logic [15:0] m_code;
  logic [15:0] m_pwd;
  int          m_cnt;
  int          m_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic snap_t m_snap();
    snap_t s;
    s.code = m_code;
    s.cnt  = 3'(m_cnt);
    s.st   = m_state;
    s.unl  = (m_state == S_OPEN);
    s.alm  = (m_state == S_LOCKOUT);
    s.setm = (m_state == S_SET);
    return s;
  endfunction

  task automatic push(input int dwell);
    exp_t e;
    e.s = m_snap();
    e.dwell = dwell;
    q.push_back(e);
  endtask

  task automatic m_clear();
    m_code = 16'hFFFF;
    m_cnt  = 0;
  endtask

  // Digit k lands in CODE_DISP[4k+3:4k]; comparison is against the raw 16-bit password.
  task automatic model_digit(input int d, input int dw);
    if (m_state == S_IDLE || m_state == S_ENTRY || m_state == S_SET) begin
      m_code[4*m_cnt +: 4] = 4'(d);
      m_cnt++;
      if (m_state == S_SET) begin
        if (m_cnt == 4) begin
          m_pwd = m_code;
          m_clear();
          m_state = S_IDLE;
        end
        push(dw);
      end else if (m_cnt < 4) begin
        m_state = S_ENTRY;
        push(dw);
      end else begin
        m_state = S_CHECK;
        push(1);
        if (m_code == m_pwd) begin
          m_fail = 0;
          m_state = S_OPEN;
          push(int'(OPN));
        end else begin
          if (m_fail < 3) m_fail++;
          m_state = S_FAIL;
          push(1);
          m_clear();
          if (m_fail == 3) begin
            m_state = S_LOCKOUT;
            push(int'(LCK));
            m_fail = 0;
            m_state = S_IDLE;
            push(0);
            m_state = S_LOCKOUT;  // model ignores digits until model_lock_done
          end else begin
            m_state = S_IDLE;
            push(0);
          end
        end
      end
    end
  endtask

  task automatic model_open_expire();
    m_clear();
    m_state = S_IDLE;
    push(0);
  endtask

  task automatic model_lock_done();
    m_state = S_IDLE;
  endtask

  task automatic model_btn_set();
    if (m_state == S_OPEN) begin
      if (q.size() > 0) q[$].dwell = 0;
      m_clear();
      m_state = S_SET;
      push(0);
    end
  endtask

  task automatic model_abort();
    if (m_state == S_ENTRY || m_state == S_SET) begin
      m_clear();
      m_state = S_IDLE;
      push(0);
    end
  endtask

  task automatic model_reset();
    m_pwd  = DEF;
    m_fail = 0;
    if (m_code != 16'hFFFF || m_cnt != 0 || m_state != S_IDLE) begin
      m_clear();
      m_state = S_IDLE;
      push(0);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int d, input int dw = 0);
    SW[d] = 1'b1;
    model_digit(d, dw);
    cyc(12);
    SW[d] = 1'b0;
    cyc(12);
  endtask

  task automatic press_seq(input int a, input int b, input int c, input int d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  // Output-change monitor.
  logic  mon_en = 1'b0;
  snap_t prev_s;
  int    hold = 0;
  int    pend = 0;

  initial begin
    snap_t cur_s;
    exp_t  e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cur_s = {CODE_DISP, DIGIT_CNT, STATE, UNLOCK, ALARM, SET_MODE};
        if (cur_s !== prev_s) begin
          if (pend != 0) check("dwell", 32'(hold), 32'(pend));
          if (q.size() == 0) begin
            check("spurious_change", 32'(cur_s), 32'(prev_s));
            pend = 0;
          end else begin
            e = q.pop_front();
            check("snapshot", 32'(cur_s), 32'(e.s));
            pend = e.dwell;
          end
          hold   = 1;
          prev_s = cur_s;
        end else begin
          hold++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_state = S_IDLE;
    m_pwd   = DEF;
    m_fail  = 0;
    m_clear();

    cyc(3);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_code_disp", 32'(CODE_DISP), 32'h0000_FFFF);
    check("rst_digit_cnt", 32'(DIGIT_CNT), 32'd0);
    check("rst_unlock",    32'(UNLOCK),    32'd0);
    check("rst_alarm",     32'(ALARM),     32'd0);
    check("rst_set_mode",  32'(SET_MODE),  32'd0);
    check("rst_state",     32'(STATE),     32'(S_IDLE));
    prev_s = m_snap();
    mon_en = 1'b1;
    cyc(2);

    // Default password 16'h1234 keyed as 4,3,2,1; OPEN for OPN cycles.
    press_seq(4, 3, 2, 1);
    model_open_expire();
    cyc(30);

    // Three wrong entries -> lockout; a switch edge during lockout is ignored.
    press_seq(5, 5, 5, 5);
    press_seq(5, 5, 5, 5);
    press_seq(5, 5, 5, 5);
    press(2);
    cyc(40);
    model_lock_done();

    // 1,2,3,4 gives 16'h4321, which is not the default password.
    press_seq(1, 2, 3, 4);
    cyc(5);

    // Bouncing switch never settles long enough to register.
    for (int i = 0; i < 10; i++) begin
      SW[3] = ~SW[3];
      cyc(2);
    end
    cyc(12);

    // SW0 rising while SW7 is held is dropped; then clear the one digit.
    SW[7] = 1'b1;
    model_digit(7, 0);
    cyc(12);
    SW[0] = 1'b1;
    cyc(12);
    SW = '0;
    cyc(12);
    BTN_CLR = 1'b1;
    model_abort();
    cyc(12);
    BTN_CLR = 1'b0;
    cyc(12);

    // Inactivity timeout after two digits.
    press(7);
    press(8, int'(TMO));
    model_abort();
    cyc(100);

    // BTN_CLR on the same cycle as a digit edge wins.
    press(7);
    SW[8]   = 1'b1;
    BTN_CLR = 1'b1;
    model_abort();
    cyc(12);
    SW[8]   = 1'b0;
    BTN_CLR = 1'b0;
    cyc(12);

    // Unlock, enter SET, program 9,0,9,0 -> password 16'h0909.
    press(4);
    press(3);
    press(2);
    SW[1] = 1'b1;
    model_digit(1, 0);
    cyc(4);
    BTN_SET = 1'b1;
    model_btn_set();
    cyc(12);
    SW[1]   = 1'b0;
    BTN_SET = 1'b0;
    cyc(12);
    press_seq(9, 0, 9, 0);
    cyc(5);
    press_seq(1, 2, 3, 4);
    cyc(5);
    press_seq(9, 0, 9, 0);
    model_open_expire();
    cyc(30);

    // Reset mid-entry restores outputs and the default password.
    press(9);
    press(0);
    model_reset();
    RESET = 1'b1;
    cyc(2);
    RESET = 1'b0;
    cyc(5);
    press_seq(4, 3, 2, 1);
    model_open_expire();
    cyc(30);

    cyc(10);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
